// File: rtl/dsm_carry_decoder.sv
// Carry-stream decoder for the first-order DSM accumulator.
// Counts carries over a window of 2^W enabled samples and reports the count
// as the recovered fractional word, with valid, stability and saturation flags.
module dsm_carry_decoder #(
   parameter int unsigned W = 7
) (
   input  logic         Clk,
   input  logic         reset,
   input  logic         En,
   input  logic         Cin,
   input  logic         Restart,
   output logic [W-1:0] Out_Data,
   output logic         Valid,
   output logic         Stable,
   output logic         Sat
);

   logic [W-1:0] win_cnt_q, win_cnt_d;
   logic [W:0]   ones_cnt_q, ones_cnt_d;
   logic         prev_ok_q, prev_ok_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         valid_q, valid_d;
   logic         stable_q, stable_d;
   logic         sat_q, sat_d;

   logic [W:0]   total;
   logic         win_end;
   logic         sat_new;
   logic [W-1:0] data_new;

   // Window-end decode: the count can reach 2^W, which does not fit in W bits,
   // so it is clamped to all-ones and flagged.
   always_comb begin
      total    = ones_cnt_q + (W+1)'(Cin);
      win_end  = En && (win_cnt_q == {W{1'b1}});
      sat_new  = total[W];
      data_new = sat_new ? {W{1'b1}} : total[W-1:0];
   end

   // Next-state: Restart beats window end, window end beats normal counting.
   always_comb begin
      win_cnt_d  = win_cnt_q;
      ones_cnt_d = ones_cnt_q;
      prev_ok_d  = prev_ok_q;
      out_data_d = out_data_q;
      valid_d    = 1'b0;
      stable_d   = stable_q;
      sat_d      = sat_q;
      if (Restart) begin
         win_cnt_d  = '0;
         ones_cnt_d = '0;
         prev_ok_d  = 1'b0;
         stable_d   = 1'b0;
      end else if (win_end) begin
         win_cnt_d  = '0;
         ones_cnt_d = '0;
         out_data_d = data_new;
         sat_d      = sat_new;
         valid_d    = 1'b1;
         // Compare clamped values so two saturated windows count as stable.
         stable_d   = prev_ok_q && (data_new == out_data_q);
         prev_ok_d  = 1'b1;
      end else if (En) begin
         win_cnt_d  = win_cnt_q + W'(1);
         ones_cnt_d = total;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!reset) begin
         win_cnt_q  <= '0;
         ones_cnt_q <= '0;
         prev_ok_q  <= 1'b0;
         out_data_q <= '0;
         valid_q    <= 1'b0;
         stable_q   <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         win_cnt_q  <= win_cnt_d;
         ones_cnt_q <= ones_cnt_d;
         prev_ok_q  <= prev_ok_d;
         out_data_q <= out_data_d;
         valid_q    <= valid_d;
         stable_q   <= stable_d;
         sat_q      <= sat_d;
      end
   end

   // Outputs are driven straight from registers.
   always_comb begin
      Out_Data = out_data_q;
      Valid    = valid_q;
      Stable   = stable_q;
      Sat      = sat_q;
   end

endmodule

// File: tb/tb_dsm_carry_decoder.sv
// Directed bench for dsm_carry_decoder: a behavioural 7-bit DSM accumulator
// produces the carry stream, and each scenario task checks the decoded window.
module tb_dsm_carry_decoder;

   localparam int unsigned W = 7;

   logic         Clk = 1'b0;
   logic         reset;
   logic         En;
   logic         Cin;
   logic         Restart;
   logic [W-1:0] Out_Data;
   logic         Valid;
   logic         Stable;
   logic         Sat;

   int vectors = 0;
   int miscompares = 0;

   // DSM model state and stimulus controls
   logic [6:0] acc = '0;
   logic [6:0] in_word = '0;
   bit         use_forced = 1'b0;
   logic       forced_cin = 1'b0;
   int         exp_ones = 0;

   dsm_carry_decoder #(.W(W)) dut (
      .Clk      (Clk),
      .reset    (reset),
      .En       (En),
      .Cin      (Cin),
      .Restart  (Restart),
      .Out_Data (Out_Data),
      .Valid    (Valid),
      .Stable   (Stable),
      .Sat      (Sat)
   );

   always #5 Clk = ~Clk;

   function automatic logic [6:0] dec(input int ones);
      logic [6:0] r;
      r = (ones >= 128) ? 7'd127 : 7'(ones);
      return r;
   endfunction

   task automatic tick(input logic en, input logic cin);
      En  = en;
      Cin = cin;
      @(posedge Clk);
      #1;
   endtask

   // Drive n enabled samples (alt inserts a disabled cycle before each one, with
   // Cin=1 that must be ignored). Counts Valid pulses seen before the last sample.
   task automatic drive(input int n, input bit alt, output int early);
      logic [7:0] sum;
      logic       c;
      early = 0;
      sum   = '0;
      for (int i = 0; i < n; i++) begin
         if (alt) begin
            tick(1'b0, 1'b1);
            if (Valid) early++;
         end
         if (use_forced) begin
            c = forced_cin;
         end else begin
            sum = {1'b0, acc} + {1'b0, in_word};
            c   = sum[7];
         end
         tick(1'b1, c);
         if (!use_forced) acc = sum[6:0];
         exp_ones += int'(c);
         if (i != n - 1 && Valid) early++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; Restart = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      vectors++; if (Out_Data !== 7'd0) begin miscompares++; $display("FAIL reset_out got %0d exp 0", Out_Data); end
      vectors++; if (Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", Valid); end
      vectors++; if (Stable !== 1'b0) begin miscompares++; $display("FAIL reset_stable got %b exp 0", Stable); end
      vectors++; if (Sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat got %b exp 0", Sat); end
   endtask

   task automatic test_const_one;
      int early;
      reset = 1'b1; acc = '0; in_word = 7'd1;
      drive(128, 1'b0, early);
      vectors++; if (early !== 0) begin miscompares++; $display("FAIL w1_early_valid got %0d exp 0", early); end
      vectors++; if (Valid !== 1'b1) begin miscompares++; $display("FAIL w1_valid got %b exp 1", Valid); end
      vectors++; if (Out_Data !== 7'd1) begin miscompares++; $display("FAIL w1_out got %0d exp 1", Out_Data); end
      vectors++; if (Sat !== 1'b0) begin miscompares++; $display("FAIL w1_sat got %b exp 0", Sat); end
      vectors++; if (Stable !== 1'b0) begin miscompares++; $display("FAIL w1_stable got %b exp 0", Stable); end
      tick(1'b0, 1'b1);
      vectors++; if (Valid !== 1'b0) begin miscompares++; $display("FAIL w1_pulse_len got %b exp 0", Valid); end
      vectors++; if (Out_Data !== 7'd1) begin miscompares++; $display("FAIL w1_hold got %0d exp 1", Out_Data); end
      drive(128, 1'b0, early);
      vectors++; if (early !== 0) begin miscompares++; $display("FAIL w2_early_valid got %0d exp 0", early); end
      vectors++; if (Valid !== 1'b1 || Out_Data !== 7'd1) begin miscompares++; $display("FAIL w2_out got v=%b d=%0d exp v=1 d=1", Valid, Out_Data); end
      vectors++; if (Stable !== 1'b1) begin miscompares++; $display("FAIL w2_stable got %b exp 1", Stable); end
   endtask

   task automatic test_change;
      int early, e1, e2;
      logic [6:0] w3;
      exp_ones = 0;
      drive(60, 1'b0, early);
      e1 = early;
      in_word = 7'd2;
      drive(68, 1'b0, early);
      e2 = early;
      w3 = dec(exp_ones);
      vectors++; if (e1 + e2 !== 0 || Valid !== 1'b1) begin miscompares++; $display("FAIL w3_valid got early=%0d v=%b exp early=0 v=1", e1 + e2, Valid); end
      vectors++; if (Out_Data !== w3) begin miscompares++; $display("FAIL w3_out got %0d exp %0d", Out_Data, w3); end
      vectors++; if (Stable !== (w3 == 7'd1)) begin miscompares++; $display("FAIL w3_stable got %b exp %b", Stable, w3 == 7'd1); end
      exp_ones = 0;
      drive(128, 1'b0, early);
      vectors++; if (Out_Data !== 7'd2 || exp_ones != 2) begin miscompares++; $display("FAIL w4_out got %0d model %0d exp 2", Out_Data, exp_ones); end
      vectors++; if (Stable !== (w3 == 7'd2)) begin miscompares++; $display("FAIL w4_stable got %b exp %b", Stable, w3 == 7'd2); end
      drive(128, 1'b0, early);
      vectors++; if (Valid !== 1'b1 || Out_Data !== 7'd2 || Stable !== 1'b1) begin miscompares++; $display("FAIL w5 got v=%b d=%0d s=%b exp v=1 d=2 s=1", Valid, Out_Data, Stable); end
   endtask

   task automatic test_saturate;
      int early;
      use_forced = 1'b1; forced_cin = 1'b1;
      drive(128, 1'b0, early);
      vectors++; if (Out_Data !== 7'd127 || Sat !== 1'b1) begin miscompares++; $display("FAIL sat_full got d=%0d sat=%b exp d=127 sat=1", Out_Data, Sat); end
      vectors++; if (Stable !== 1'b0) begin miscompares++; $display("FAIL sat_stable got %b exp 0", Stable); end
      drive(127, 1'b0, early);
      forced_cin = 1'b0;
      drive(1, 1'b0, early);
      vectors++; if (Out_Data !== 7'd127 || Sat !== 1'b0) begin miscompares++; $display("FAIL ones127 got d=%0d sat=%b exp d=127 sat=0", Out_Data, Sat); end
      vectors++; if (Stable !== 1'b1) begin miscompares++; $display("FAIL ones127_stable got %b exp 1", Stable); end
      use_forced = 1'b0; in_word = 7'd5;
      drive(128, 1'b0, early);
      vectors++; if (Valid !== 1'b1 || Out_Data !== 7'd5 || Sat !== 1'b0) begin miscompares++; $display("FAIL in5 got v=%b d=%0d sat=%b exp v=1 d=5 sat=0", Valid, Out_Data, Sat); end
      vectors++; if (Stable !== 1'b0) begin miscompares++; $display("FAIL in5_stable got %b exp 0", Stable); end
   endtask

   task automatic test_alt_enable;
      int early;
      in_word = 7'd3;
      drive(128, 1'b1, early);
      vectors++; if (early !== 0) begin miscompares++; $display("FAIL alt_early_valid got %0d exp 0", early); end
      vectors++; if (Valid !== 1'b1 || Out_Data !== 7'd3) begin miscompares++; $display("FAIL alt_out got v=%b d=%0d exp v=1 d=3", Valid, Out_Data); end
      drive(128, 1'b1, early);
      vectors++; if (early !== 0 || Valid !== 1'b1 || Out_Data !== 7'd3 || Stable !== 1'b1) begin miscompares++; $display("FAIL alt_w2 got early=%0d v=%b d=%0d s=%b exp 0 1 3 1", early, Valid, Out_Data, Stable); end
   endtask

   task automatic test_restart_window_end;
      int early;
      drive(127, 1'b0, early);
      Restart = 1'b1;
      drive(1, 1'b0, early);
      Restart = 1'b0;
      vectors++; if (Valid !== 1'b0) begin miscompares++; $display("FAIL restart_valid got %b exp 0", Valid); end
      vectors++; if (Out_Data !== 7'd3 || Stable !== 1'b0) begin miscompares++; $display("FAIL restart_hold got d=%0d s=%b exp d=3 s=0", Out_Data, Stable); end
      drive(128, 1'b0, early);
      vectors++; if (early !== 0 || Valid !== 1'b1 || Out_Data !== 7'd3 || Stable !== 1'b0) begin miscompares++; $display("FAIL post_restart got early=%0d v=%b d=%0d s=%b exp 0 1 3 0", early, Valid, Out_Data, Stable); end
   endtask

   task automatic test_reset_mid;
      int early;
      in_word = 7'd4;
      drive(70, 1'b0, early);
      reset = 1'b0;
      drive(1, 1'b0, early);
      vectors++; if (Out_Data !== 7'd0 || Valid !== 1'b0 || Stable !== 1'b0 || Sat !== 1'b0) begin miscompares++; $display("FAIL mid_reset got d=%0d v=%b s=%b sat=%b exp all 0", Out_Data, Valid, Stable, Sat); end
      reset = 1'b1;
      tick(1'b0, 1'b1);
      drive(128, 1'b0, early);
      vectors++; if (early !== 0) begin miscompares++; $display("FAIL post_reset_early got %0d exp 0", early); end
      vectors++; if (Valid !== 1'b1 || Out_Data !== 7'd4) begin miscompares++; $display("FAIL post_reset_out got v=%b d=%0d exp v=1 d=4", Valid, Out_Data); end
   endtask

   initial begin
      reset = 1'b0; En = 1'b0; Cin = 1'b0; Restart = 1'b0;
      test_reset;
      test_const_one;
      test_change;
      test_saturate;
      test_alt_enable;
      test_restart_window_end;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dsm_carry_decoder.md
Name: dsm_carry_decoder

Overview:
- Decodes the 1-bit carry stream (Cout) of the first-order DSM accumulator back into the fractional word that produced it.
- Counts carries over a window of exactly 2^W enabled clocks. For an ideal accumulator, the count equals the input word for any window alignment.
- Used as the loop-back checker and debug readout for the DSM feeding the PLL divider. Also used in-system to confirm that the programmed fraction is reaching the divider.

Parameters:
- W, 7, width of the DSM data word; the window length is 2^W enabled samples.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
- En  input  1  sample enable; Cin is counted and the window advances only when En=1.
- Cin  input  1  carry bit from the DSM accumulator.
- Restart  input  1  synchronous window realign; discards the partial window.
- Out_Data  output  W  decoded fraction from the last completed window.
- Valid  output  1  one-cycle pulse when Out_Data updates.
- Stable  output  1  high when the last two completed windows decoded to the same value.
- Sat  output  1  high when the last window counted 2^W ones.

Behaviour:
- Reset (reset=0 at a rising edge): all internal state is cleared and all outputs go to 0:
  - Win_Cnt (W bits), Ones_Cnt (W+1 bits) and the have-previous flag Prev_Ok.
  - Out_Data, Valid, Stable, Sat.
  - Reset mid-window discards the partial count; the first window after reset starts with the first enabled sample after reset is released.
- Enabled cycle that is not the last in the window (En=1, Win_Cnt != 2^W-1):
  - Win_Cnt increments.
  - Ones_Cnt adds Cin.
- Window end (En=1 and Win_Cnt = 2^W-1): Total = Ones_Cnt + Cin, computed in W+1 bits. On this edge:
  - If Total = 2^W: Out_Data <= 2^W-1 (saturated) and Sat <= 1. Otherwise Out_Data <= Total[W-1:0] and Sat <= 0.
  - Valid <= 1.
  - Stable <= Prev_Ok AND (new Out_Data equals the old Out_Data), comparing the saturated values. Prev_Ok <= 1.
  - Win_Cnt wraps to 0 and Ones_Cnt <= 0.
- Latency: Out_Data and Valid are registered and become visible in the cycle after the edge that samples the last Cin of the window.
- Valid is high for exactly one cycle per completed window. It is 0 on every other cycle, including cycles with En=0.
- En=0: Win_Cnt and Ones_Cnt hold, and Cin is ignored. Out_Data, Stable and Sat hold their last values.
- Restart=1 with reset=1:
  - Win_Cnt <= 0, Ones_Cnt <= 0, Prev_Ok <= 0, Stable <= 0 and Valid <= 0.
  - Out_Data and Sat hold their last values.
  - Restart takes priority over a coincident window end: that window is discarded and no Valid is produced.
- Priority, highest first: reset, then Restart, then window end, then normal count.
- Stable stays 0 until at least two windows have completed since the last reset or Restart.

Test Plan:
- Clk period 10 ns; Cin is driven by a behavioural model of the 7-bit DSM accumulator; En=1 unless stated; W=7.
- In=7'd1 from reset release -> Valid pulses every 128 cycles with Out_Data=1, Sat=0. Stable=0 after the first window and 1 after the second.
- In changed from 1 to 2 at cycle 60 of window 3 -> window 3 decodes to 1 or 2 per the model and Stable drops on the mismatch. Window 4 decodes to 2 with Stable=0; window 5 decodes to 2 with Stable=1.
- Cin held at 1 for a full window -> Out_Data=127, Sat=1. The next window with In=5 gives Out_Data=5, Sat=0, Stable=0.
- En toggled on alternate cycles with In=3 -> Valid every 256 clocks, Out_Data=3. Valid is never high while En=0 except on the registered pulse cycle.
- Restart asserted on the exact window-end cycle -> no Valid on the next cycle, Out_Data keeps its old value, Stable=0. The next full window decodes correctly.
- reset=0 asserted at cycle 70 of a window with In=4 -> all outputs are 0 on the next cycle. After release, the first Valid comes exactly 128 enabled cycles later with Out_Data=4.
